// File: rtl/pmem_drain.sv
// Read-out engine: walks two pmem address streams and packs result pairs into a valid/ready FIFO.
// Define PMEM_DRAIN_RELU_EN to clamp negative result bytes to zero before they are buffered.
module pmem_drain #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned PMEM_ADDR_WIDTH = 8,
   parameter int unsigned FIFO_DEPTH      = 4
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   input  logic [PMEM_ADDR_WIDTH-1:0]   i_base_addr0,
   input  logic [PMEM_ADDR_WIDTH-1:0]   i_base_addr1,
   input  logic [PMEM_ADDR_WIDTH-1:0]   i_count,
   output logic                         o_busy,
   output logic                         o_done,
   output logic                         o_pmem_rd_en,
   output logic [PMEM_ADDR_WIDTH-1:0]   o_pmem_rd_addr0,
   output logic [PMEM_ADDR_WIDTH-1:0]   o_pmem_rd_addr1,
   input  logic [DATA_WIDTH-1:0]        i_pmem_rd_data0,
   input  logic [DATA_WIDTH-1:0]        i_pmem_rd_data1,
   output logic                         o_valid,
   output logic [2*DATA_WIDTH-1:0]      o_data,
   input  logic                         i_ready
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned OccW = PtrW + 1;
   localparam int unsigned SumW = OccW + 1;
   localparam logic [PMEM_ADDR_WIDTH-1:0] AddrOne = 1;
   localparam logic [PtrW-1:0]            PtrOne  = 1;
   localparam logic [OccW-1:0]            OccOne  = 1;

   typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

   state_e                      state_q, state_d;
   logic [PMEM_ADDR_WIDTH-1:0]  remain_q, remain_d;
   logic [PMEM_ADDR_WIDTH-1:0]  addr0_q, addr0_d;
   logic [PMEM_ADDR_WIDTH-1:0]  addr1_q, addr1_d;
   logic                        rd_en_q, rd_en_d;
   logic                        rvalid_q;
   logic [PtrW-1:0]             wr_ptr_q, rd_ptr_q;
   logic [OccW-1:0]             occ_q, occ_d;
   logic [2*DATA_WIDTH-1:0]     mem_q [FIFO_DEPTH];
   logic [2*DATA_WIDTH-1:0]     push_data;
   logic                        push, pop, can_issue;
   logic [1:0]                  inflight;
   logic [SumW-1:0]             committed, limit;

   assign push     = rvalid_q;
   assign pop      = o_valid & i_ready;
   assign inflight = {1'b0, rd_en_q} + {1'b0, rvalid_q};

   // Issue credit: slots already claimed must stay below depth, a same-cycle pop frees one.
   assign committed = SumW'(occ_q) + SumW'(inflight);
   assign limit     = SumW'(FIFO_DEPTH) + SumW'(pop);
   assign can_issue = committed < limit;

`ifdef PMEM_DRAIN_RELU_EN
   logic [DATA_WIDTH-1:0] relu0, relu1;
   assign relu0     = i_pmem_rd_data0[DATA_WIDTH-1] ? '0 : i_pmem_rd_data0;
   assign relu1     = i_pmem_rd_data1[DATA_WIDTH-1] ? '0 : i_pmem_rd_data1;
   assign push_data = {relu1, relu0};
`else
   assign push_data = {i_pmem_rd_data1, i_pmem_rd_data0};
`endif

   always_comb begin
      occ_d = occ_q;
      case ({push, pop})
         2'b10:   occ_d = occ_q + OccOne;
         2'b01:   occ_d = occ_q - OccOne;
         default: occ_d = occ_q;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      remain_d = remain_q;
      addr0_d  = addr0_q;
      addr1_d  = addr1_q;
      rd_en_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            // The first read goes out with the start so data returns two cycles later.
            if (i_start) begin
               if (i_count != '0) begin
                  state_d  = StRead;
                  rd_en_d  = 1'b1;
                  addr0_d  = i_base_addr0;
                  addr1_d  = i_base_addr1;
                  remain_d = i_count - AddrOne;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StRead: begin
            if (remain_q == '0) begin
               state_d = StDrain;
            end else if (can_issue) begin
               rd_en_d  = 1'b1;
               addr0_d  = addr0_q + AddrOne;
               addr1_d  = addr1_q + AddrOne;
               remain_d = remain_q - AddrOne;
               if (remain_q == AddrOne) state_d = StDrain;
            end
         end
         StDrain: begin
            // No issue here, so only a read on the bus now can still be in flight next cycle.
            if (!rd_en_q && occ_d == '0) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= StIdle;
         remain_q <= '0;
         addr0_q  <= '0;
         addr1_q  <= '0;
         rd_en_q  <= 1'b0;
         rvalid_q <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         state_q  <= state_d;
         remain_q <= remain_d;
         addr0_q  <= addr0_d;
         addr1_q  <= addr1_d;
         rd_en_q  <= rd_en_d;
         rvalid_q <= rd_en_q;
         occ_q    <= occ_d;
         if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push && !i_rst) mem_q[wr_ptr_q] <= push_data;
   end

   assign o_busy          = (state_q == StRead) || (state_q == StDrain);
   assign o_done          = (state_q == StDone);
   assign o_pmem_rd_en    = rd_en_q;
   assign o_pmem_rd_addr0 = addr0_q;
   assign o_pmem_rd_addr1 = addr1_q;
   assign o_valid         = (occ_q != '0);
   assign o_data          = o_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_pmem_drain.sv
// Scoreboard bench for pmem_drain: jobs push expected words/addresses, a negedge monitor checks.
module tb_pmem_drain;
   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;
   localparam int unsigned FD = 4;

   logic            i_clk = 1'b0;
   logic            i_rst, i_start, i_ready;
   logic [AW-1:0]   i_base_addr0, i_base_addr1, i_count;
   logic            o_busy, o_done, o_pmem_rd_en, o_valid;
   logic [AW-1:0]   o_pmem_rd_addr0, o_pmem_rd_addr1;
   logic [DW-1:0]   i_pmem_rd_data0, i_pmem_rd_data1;
   logic [2*DW-1:0] o_data;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int rmode = 0;
   logic [DW-1:0] x0 = '0, x1 = '0;

   logic [2*DW-1:0] exp_q[$];
   logic [2*AW-1:0] addr_q[$];
   logic [2*DW-1:0] got_q[$];
   int              got_cyc[$];
   int              occ = 0;
   bit              prev_rd = 1'b0;

   pmem_drain #(.DATA_WIDTH(DW), .PMEM_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_start         (i_start),
      .i_base_addr0    (i_base_addr0),
      .i_base_addr1    (i_base_addr1),
      .i_count         (i_count),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_pmem_rd_en    (o_pmem_rd_en),
      .o_pmem_rd_addr0 (o_pmem_rd_addr0),
      .o_pmem_rd_addr1 (o_pmem_rd_addr1),
      .i_pmem_rd_data0 (i_pmem_rd_data0),
      .i_pmem_rd_data1 (i_pmem_rd_data1),
      .o_valid         (o_valid),
      .o_data          (o_data),
      .i_ready         (i_ready)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // pmem model: registered read, data = address XOR a per-job pattern.
   always @(posedge i_clk) begin
      if (o_pmem_rd_en === 1'b1) begin
         i_pmem_rd_data0 <= o_pmem_rd_addr0 ^ x0;
         i_pmem_rd_data1 <= o_pmem_rd_addr1 ^ x1;
      end
   end

   function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
`ifdef PMEM_DRAIN_RELU_EN
      return v[DW-1] ? '0 : v;
`else
      return v;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Consumer: 0 always ready, 1 pattern 1,0,0,1, 2 random, 3 never ready.
   initial begin
      i_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         case (rmode)
            0:       i_ready = 1'b1;
            1:       i_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       i_ready = 1'($urandom_range(0, 1));
            default: i_ready = 1'b0;
         endcase
      end
   end

   // Monitor: checks read addresses, popped words and occupancy against the scoreboard.
   always @(negedge i_clk) begin
      bit pop;
      if (i_rst) begin
         occ     = 0;
         prev_rd = 1'b0;
         exp_q.delete();
         addr_q.delete();
      end else begin
         if (o_pmem_rd_en) begin
            if (addr_q.size() == 0) check("spurious rd_en", 32'(o_pmem_rd_en), 32'd0);
            else check("rd addr pair", 32'({o_pmem_rd_addr1, o_pmem_rd_addr0}),
                       32'(addr_q.pop_front()));
         end
         check("o_valid vs model occupancy", 32'(o_valid), 32'(occ != 0));
         pop = o_valid && i_ready;
         if (pop) begin
            got_q.push_back(o_data);
            got_cyc.push_back(cyc);
            if (exp_q.size() == 0) check("unexpected word", 32'(o_data), 32'hFFFF_FFFF);
            else check("o_data", 32'(o_data), 32'(exp_q.pop_front()));
         end
         occ = occ + int'(prev_rd) - int'(pop);
         tests++;
         if (occ > int'(FD) || occ < 0) begin
            fails++;
            $display("FAIL occupancy: got %0d, expected 0..%0d (cycle %0d)", occ, FD, cyc);
         end
         prev_rd = o_pmem_rd_en;
      end
   end

   task automatic load_job(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                           input logic [AW-1:0] cnt, input logic [DW-1:0] d0x,
                           input logic [DW-1:0] d1x);
      x0 = d0x;
      x1 = d1x;
      got_q.delete();
      got_cyc.delete();
      for (int k = 0; k < int'(cnt); k++) begin
         logic [AW-1:0] a0, a1;
         a0 = b0 + AW'(k);
         a1 = b1 + AW'(k);
         addr_q.push_back({a1, a0});
         exp_q.push_back({relu(a1 ^ d1x), relu(a0 ^ d0x)});
      end
   endtask

   task automatic issue_start(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                              input logic [AW-1:0] cnt, output int st);
      @(posedge i_clk);
      #1;
      st           = cyc;
      i_start      = 1'b1;
      i_base_addr0 = b0;
      i_base_addr1 = b1;
      i_count      = cnt;
      @(posedge i_clk);
      #1;
      i_start = 1'b0;
   endtask

   task automatic run_job(input logic [AW-1:0] b0, input logic [AW-1:0] b1,
                          input logic [AW-1:0] cnt, input logic [DW-1:0] d0x,
                          input logic [DW-1:0] d1x, input int rm, output int st,
                          output int done_rel, output int valid_rel, output bit saw_busy);
      rmode = rm;
      load_job(b0, b1, cnt, d0x, d1x);
      issue_start(b0, b1, cnt, st);
      done_rel  = -1;
      valid_rel = -1;
      saw_busy  = 1'b0;
      for (int c = 1; c < 3000; c++) begin
         if (o_busy) saw_busy = 1'b1;
         if (o_valid && valid_rel < 0) valid_rel = c;
         if (o_done) begin
            done_rel = c;
            break;
         end
         @(posedge i_clk);
         #1;
      end
      if (done_rel < 0) begin
         check("done timeout", 32'd0, 32'd1);
      end else begin
         @(posedge i_clk);
         #1;
         check("done one cycle", 32'(o_done), 32'd0);
         check("busy low after done", 32'(o_busy), 32'd0);
      end
      check("words undelivered", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int  st, dr, vr;
      bit  sb;
      logic [15:0] basic_exp [4];
      logic [15:0] relu_exp;
      i_rst = 1'b1;
      i_start = 1'b0;
      i_base_addr0 = '0;
      i_base_addr1 = '0;
      i_count = '0;
      repeat (3) @(posedge i_clk);
      #1;
      check("reset o_busy", 32'(o_busy), 32'd0);
      check("reset o_done", 32'(o_done), 32'd0);
      check("reset o_valid", 32'(o_valid), 32'd0);
      check("reset o_pmem_rd_en", 32'(o_pmem_rd_en), 32'd0);
      check("reset addr0", 32'(o_pmem_rd_addr0), 32'd0);
      check("reset addr1", 32'(o_pmem_rd_addr1), 32'd0);
      check("reset o_data", 32'(o_data), 32'd0);
      i_rst = 1'b0;

      // Basic drain with exact timing.
      basic_exp[0] = 16'h8010;
      basic_exp[1] = 16'h8111;
      basic_exp[2] = 16'h8212;
      basic_exp[3] = 16'h8313;
      run_job(8'h10, 8'h80, 8'd4, 8'h00, 8'h00, 0, st, dr, vr, sb);
      check("basic first valid cycle", 32'(vr), 32'd3);
      check("basic done cycle", 32'(dr), 32'd7);
      check("basic word count", 32'(got_q.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_q.size(); i++) begin
         check("basic word", 32'(got_q[i]), 32'(basic_exp[i]));
         check("basic pop cycle", 32'(got_cyc[i] - st), 32'(3 + i));
      end

      // Backpressure with 1,0,0,1 consumer.
      run_job(8'h20, 8'h40, 8'd8, 8'h00, 8'h00, 1, st, dr, vr, sb);
      check("backpressure word count", 32'(got_q.size()), 32'd8);

      // Empty job.
      run_job(8'h33, 8'h44, 8'd0, 8'h00, 8'h00, 0, st, dr, vr, sb);
      check("empty done cycle", 32'(dr), 32'd1);
      check("empty busy never high", 32'(sb), 32'd0);

      // Address wrap-around.
      run_job(8'hFE, 8'hFD, 8'd4, 8'h00, 8'h00, 0, st, dr, vr, sb);
      check("wrap word count", 32'(got_q.size()), 32'd4);

      // Reset mid-job with a stalled consumer.
      rmode = 3;
      load_job(8'h50, 8'h60, 8'd8, 8'h00, 8'h00);
      issue_start(8'h50, 8'h60, 8'd8, st);
      @(posedge i_clk);
      #1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst = 1'b0;
      check("mid reset o_valid", 32'(o_valid), 32'd0);
      check("mid reset o_busy", 32'(o_busy), 32'd0);
      check("mid reset o_done", 32'(o_done), 32'd0);
      check("mid reset o_pmem_rd_en", 32'(o_pmem_rd_en), 32'd0);
      check("mid reset addr0", 32'(o_pmem_rd_addr0), 32'd0);
      check("mid reset addr1", 32'(o_pmem_rd_addr1), 32'd0);
      run_job(8'h70, 8'h90, 8'd2, 8'h00, 8'h00, 0, st, dr, vr, sb);
      check("post reset word count", 32'(got_q.size()), 32'd2);

      // ReLU byte clamp.
`ifdef PMEM_DRAIN_RELU_EN
      relu_exp = 16'h7F00;
`else
      relu_exp = 16'h7F85;
`endif
      run_job(8'h85, 8'h7F, 8'd1, 8'h00, 8'h00, 0, st, dr, vr, sb);
      if (got_q.size() == 0) check("relu word present", 32'd0, 32'd1);
      else check("relu word", 32'(got_q[0]), 32'(relu_exp));

      // Randomized jobs.
      for (int j = 0; j < 25; j++) begin
         run_job(AW'($urandom), AW'($urandom), AW'($urandom_range(0, 20)), DW'($urandom),
                 DW'($urandom), int'($urandom_range(0, 2)), st, dr, vr, sb);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
